hps_cmd_bridge: RTL and testbench
=================================

# hps_cmd_bridge

- HPS-facing command front end for the VGA object engine.
- Sits between the Avalon-MM lightweight bridge port (hps_writedata/hps_address/hps_write/hps_chipselect) and the renderer inside fpga_top_level.
- Gathers byte writes into staging registers, commits a complete 56-bit object command on a write to address 6, and buffers commands in a 4-entry FIFO.
- The renderer drains the FIFO with a valid/ready handshake.

## Interface
- DEPTH, 4, FIFO entries (power of two, ≥2)
- clk  in  1  system clock (50 MHz)
- reset  in  1  asynchronous, active-low reset
- hps_chipselect  in  1  slave select; writes and reads are ignored when low
- hps_write  in  1  write strobe, qualified by hps_chipselect
- hps_read  in  1  read strobe, qualified by hps_chipselect
- hps_address  in  3  register index 0–7
- hps_writedata  in  8  write byte
- hps_readdata  out  8  read byte, registered
- cmd_valid  out  1  FIFO head holds a command
- cmd_ready  in  1  renderer accepts the head this cycle
- cmd_data  out  56  head command {tag, y, x, b, g, r, id} (MSB to LSB)
- overflow  out  1  sticky: a commit was dropped because the FIFO was full

## Operation
- Register map:
  - 0 id
  - 1 r, 2 g, 3 b
  - 4 x (8-pixel units)
  - 5 y (8-pixel units)
  - 6 tag, write = commit
  - 7 control/status
- Writes to 0–5 load the staging bytes only. Staging holds its value across commits, so only changed fields need rewriting.
- Write to 6:
  - Push {hps_writedata, stg5..stg0} into the FIFO.
  - The tag comes straight from the write data, not from a staging register.
- Write to 7:
  - Bit0 = 1 flushes the FIFO (count ← 0, pointers ← 0).
  - Bit1 = 1 clears overflow.
  - Other bits are ignored.
- Reads:
  - Address 7: hps_readdata = {3'b0, count[2:0], overflow, cmd_valid}.
  - Addresses 0–5 return the staging bytes.
  - Address 6 returns the last committed tag.
- Commit while full:
  - If cmd_ready && cmd_valid in the same cycle, the pop frees the slot and the push is accepted.
  - Otherwise the command is dropped and overflow ← 1. The FIFO is unchanged.
- Flush has priority over a push and a pop in the same cycle: the FIFO ends empty.
- A commit and a flush cannot coincide, since both are writes to different addresses.
- Pop happens when cmd_valid && cmd_ready. When the FIFO is empty, cmd_ready is a don't-care.
- cmd_data is the head entry and is stable while cmd_valid && !cmd_ready.
- Pointers wrap modulo DEPTH. count is $clog2(DEPTH)+1 bits wide, saturating by construction (0..DEPTH).
- Reset values:
  - All outputs 0: cmd_valid=0, cmd_data=0, overflow=0, hps_readdata=0.
  - Staging registers 0, last tag 0, FIFO empty.
- Reset mid-operation discards all FIFO contents immediately (asynchronous). No command is emitted after reset deasserts until a new commit.

## Timing
- Staging byte written at edge N; it is visible to a commit issued at edge N+1 or later.
- Commit at edge N into an empty FIFO: cmd_valid=1 and cmd_data valid after edge N (cycle N+1). Latency is 1 cycle.
- Pop at edge N: the next entry or cmd_valid=0 follows after edge N.
- Back-to-back commits every cycle are accepted until full.
- Read latency: hps_readdata is valid the cycle after the hps_read edge (1 wait state on the Avalon side).
- overflow sets at the dropping edge. It clears only on reset or a control write with bit1 = 1.

## Structure
- Package hps_cmd_pkg:
  - Address constants ADDR_ID…ADDR_CTRL.
  - cmd_t packed struct (tag, y, x, b, g, r, id; 8 bits each).
  - CTRL_FLUSH and CTRL_CLR_OVF bit indices.
- Sub-module cmd_fifo:
  - Parameterised DEPTH/width synchronous FIFO.
  - Interface: push, pop, flush, full, empty, count.
  - Async active-low reset.
  - Bridge logic is the decode, staging, and status mux only.

## Test plan
- Reset, then write 0:0xfd, 1:0xff, 2:0xff, 3:0xff, 4:0x00, 5:0x00, 6:0x01 -> one cycle later cmd_valid=1, cmd_data=56'h01_00_00_ff_ff_ff_fd; with cmd_ready=1 it pops and cmd_valid=0 next cycle.
- Staging retention: after the above, write 6:0x02 only -> cmd_data=56'h02_00_00_ff_ff_ff_fd.
- Overflow: hold cmd_ready=0 and commit 5 times with tags 1–5 -> count=4, overflow=1, drains in order tags 1–4; status read = 8'b000_100_1_1 before draining.
- Full with simultaneous pop: FIFO full, cmd_ready=1 on the same cycle as commit tag 9 -> accepted, overflow stays 0, tag 9 emerges 4th.
- Flush and clear: 3 entries queued, write 7:0x03 -> cmd_valid=0 and overflow=0 next cycle; a subsequent commit emerges normally.
- Async reset with 2 entries queued and hps_chipselect=0 writes interleaved -> all outputs 0 immediately; cs-low writes never alter staging.

Source files
------------

// File: rtl/hps_cmd_pkg.sv
// Shared types and constants for the HPS command bridge.
// Register map, object command layout and control bits.
package hps_cmd_pkg;

  localparam logic [2:0] ADDR_ID   = 3'd0;
  localparam logic [2:0] ADDR_R    = 3'd1;
  localparam logic [2:0] ADDR_G    = 3'd2;
  localparam logic [2:0] ADDR_B    = 3'd3;
  localparam logic [2:0] ADDR_X    = 3'd4;
  localparam logic [2:0] ADDR_Y    = 3'd5;
  localparam logic [2:0] ADDR_TAG  = 3'd6;
  localparam logic [2:0] ADDR_CTRL = 3'd7;

  localparam int CTRL_FLUSH   = 0;
  localparam int CTRL_CLR_OVF = 1;

  typedef struct packed {
    logic [7:0] tag;
    logic [7:0] y;
    logic [7:0] x;
    logic [7:0] b;
    logic [7:0] g;
    logic [7:0] r;
    logic [7:0] id;
  } cmd_t;

endpackage

// File: rtl/hps_cmd_bridge_if.sv
// Avalon-MM slave port plus renderer valid/ready command stream.
// slave: bridge side, master: HPS/renderer side.
interface hps_cmd_bridge_if;
  import hps_cmd_pkg::*;

  logic       hps_chipselect;
  logic       hps_write;
  logic       hps_read;
  logic [2:0] hps_address;
  logic [7:0] hps_writedata;
  logic [7:0] hps_readdata;
  logic       cmd_valid;
  logic       cmd_ready;
  cmd_t       cmd_data;
  logic       overflow;

  modport slave (
    input  hps_chipselect,
    input  hps_write,
    input  hps_read,
    input  hps_address,
    input  hps_writedata,
    output hps_readdata,
    output cmd_valid,
    input  cmd_ready,
    output cmd_data,
    output overflow
  );

  modport master (
    output hps_chipselect,
    output hps_write,
    output hps_read,
    output hps_address,
    output hps_writedata,
    input  hps_readdata,
    input  cmd_valid,
    output cmd_ready,
    input  cmd_data,
    input  overflow
  );

endinterface

// File: rtl/cmd_fifo.sv
// Synchronous FIFO with flush; a push while full is accepted
// only when a pop frees the head slot in the same cycle.
module cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 56
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [W-1:0]               din,
  output logic [W-1:0]               dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push)
                     - (AW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/hps_cmd_bridge.sv
// HPS command front end: byte staging, commit on tag write,
// status/readback mux and a command FIFO toward the renderer.
module hps_cmd_bridge
  import hps_cmd_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  hps_cmd_bridge_if.slave  bus
);

  localparam int CW = $clog2(DEPTH) + 1;

  cmd_t          stg;
  cmd_t          push_data;
  cmd_t          head;
  logic          wr_en;
  logic          rd_en;
  logic          commit;
  logic          ctrl_wr;
  logic          flush;
  logic          clr_ovf;
  logic          pop;
  logic          full;
  logic          empty;
  logic          drop;
  logic          ovf;
  logic [CW-1:0] count;
  logic [7:0]    cnt8;
  logic [7:0]    status;
  logic [7:0]    rd_mux;

  assign wr_en   = bus.hps_chipselect & bus.hps_write;
  assign rd_en   = bus.hps_chipselect & bus.hps_read;
  assign commit  = wr_en & (bus.hps_address == ADDR_TAG);
  assign ctrl_wr = wr_en & (bus.hps_address == ADDR_CTRL);
  assign flush   = ctrl_wr & bus.hps_writedata[CTRL_FLUSH];
  assign clr_ovf = ctrl_wr & bus.hps_writedata[CTRL_CLR_OVF];
  assign pop     = bus.cmd_ready & ~empty;
  assign drop    = commit & full & ~pop;

  // Tag comes from the bus, the rest from staging.
  always_comb begin
    push_data     = stg;
    push_data.tag = bus.hps_writedata;
  end

  cmd_fifo #(
    .DEPTH (DEPTH),
    .W     ($bits(cmd_t))
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (commit),
    .pop   (pop),
    .flush (flush),
    .din   (push_data),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  assign bus.cmd_valid = ~empty;
  assign bus.cmd_data  = head;
  assign bus.overflow  = ovf;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stg <= '0;
    end else if (wr_en) begin
      unique case (bus.hps_address)
        ADDR_ID:   stg.id  <= bus.hps_writedata;
        ADDR_R:    stg.r   <= bus.hps_writedata;
        ADDR_G:    stg.g   <= bus.hps_writedata;
        ADDR_B:    stg.b   <= bus.hps_writedata;
        ADDR_X:    stg.x   <= bus.hps_writedata;
        ADDR_Y:    stg.y   <= bus.hps_writedata;
        ADDR_TAG:  stg.tag <= bus.hps_writedata;
        ADDR_CTRL: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       ovf <= 1'b0;
    else if (drop)    ovf <= 1'b1;
    else if (clr_ovf) ovf <= 1'b0;
  end

  assign cnt8   = 8'(count);
  assign status = {3'b000, cnt8[2:0], ovf, ~empty};

  always_comb begin
    rd_mux = status;
    unique case (bus.hps_address)
      ADDR_ID:   rd_mux = stg.id;
      ADDR_R:    rd_mux = stg.r;
      ADDR_G:    rd_mux = stg.g;
      ADDR_B:    rd_mux = stg.b;
      ADDR_X:    rd_mux = stg.x;
      ADDR_Y:    rd_mux = stg.y;
      ADDR_TAG:  rd_mux = stg.tag;
      ADDR_CTRL: rd_mux = status;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)     bus.hps_readdata <= '0;
    else if (rd_en) bus.hps_readdata <= rd_mux;
  end

endmodule

// File: tb/tb_hps_cmd_bridge.sv
// Bench for hps_cmd_bridge: directed scenarios then random
// traffic, all checked against a queue-based register model.
module tb_hps_cmd_bridge;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_pass = 0;

  hps_cmd_bridge_if bus ();

  hps_cmd_bridge #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [55:0] q [$];
  logic [7:0]  m_stg [7];
  logic        m_ovf;
  logic [7:0]  m_rd;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  task automatic model_clear();
    q.delete();
    for (int i = 0; i < 7; i++) m_stg[i] = 8'h00;
    m_ovf = 1'b0;
    m_rd  = 8'h00;
  endtask

  task automatic step(input logic cs, input logic wr,
                      input logic rd, input logic [2:0] a,
                      input logic [7:0] d, input logic rdy);
    int   sz;
    logic pp;
    bus.hps_chipselect = cs;
    bus.hps_write      = wr;
    bus.hps_read       = rd;
    bus.hps_address    = a;
    bus.hps_writedata  = d;
    bus.cmd_ready      = rdy;
    @(posedge clk);
    sz = q.size();
    pp = rdy && (sz > 0);
    if (cs && rd)
      m_rd = (a == 3'd7) ? {3'b000, 3'(sz), m_ovf, sz > 0}
                         : m_stg[a];
    if (pp) void'(q.pop_front());
    if (cs && wr) begin
      if (a < 3'd6) m_stg[a] = d;
      else if (a == 3'd6) begin
        m_stg[6] = d;
        if (sz < DEPTH || pp)
          q.push_back({d, m_stg[5], m_stg[4], m_stg[3],
                       m_stg[2], m_stg[1], m_stg[0]});
        else m_ovf = 1'b1;
      end else begin
        if (d[0]) q.delete();
        if (d[1]) m_ovf = 1'b0;
      end
    end
    @(negedge clk);
    chk("valid", 64'(bus.cmd_valid), 64'(q.size() > 0));
    if (q.size() > 0) chk("data", 64'(bus.cmd_data), 64'(q[0]));
    chk("ovf", 64'(bus.overflow), 64'(m_ovf));
    chk("rdata", 64'(bus.hps_readdata), 64'(m_rd));
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d,
                    input logic rdy);
    step(1'b1, 1'b1, 1'b0, a, d, rdy);
  endtask

  task automatic rdr(input logic [2:0] a);
    step(1'b1, 1'b0, 1'b1, a, 8'h00, 1'b0);
  endtask

  task automatic idle(input logic rdy);
    step(1'b0, 1'b0, 1'b0, 3'd0, 8'h00, rdy);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, 64'(bus.cmd_valid), 64'd0);
    chk({tag, "_data"}, 64'(bus.cmd_data), 64'd0);
    chk({tag, "_ovf"}, 64'(bus.overflow), 64'd0);
    chk({tag, "_rdata"}, 64'(bus.hps_readdata), 64'd0);
  endtask

  logic [7:0] exp4 [4];
  logic [7:0] init_v [7];

  initial begin
    bus.hps_chipselect = 1'b0;
    bus.hps_write      = 1'b0;
    bus.hps_read       = 1'b0;
    bus.hps_address    = 3'd0;
    bus.hps_writedata  = 8'h00;
    bus.cmd_ready      = 1'b0;
    model_clear();
    repeat (2) @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    init_v = '{8'hfd, 8'hff, 8'hff, 8'hff, 8'h00, 8'h00, 8'h01};
    for (int i = 0; i < 6; i++) wr(3'(i), init_v[i], 1'b0);
    wr(3'd6, init_v[6], 1'b0);
    chk("t1_valid", 64'(bus.cmd_valid), 64'd1);
    chk("t1_data", 64'(bus.cmd_data), 64'h01_00_00_ff_ff_ff_fd);
    idle(1'b1);
    chk("t1_pop", 64'(bus.cmd_valid), 64'd0);

    wr(3'd6, 8'h02, 1'b0);
    chk("t2_data", 64'(bus.cmd_data), 64'h02_00_00_ff_ff_ff_fd);
    rdr(3'd6);
    chk("t2_tag", 64'(bus.hps_readdata), 64'h02);
    idle(1'b1);

    for (int t = 1; t <= 5; t++) wr(3'd6, 8'(t), 1'b0);
    rdr(3'd7);
    chk("t3_stat", 64'(bus.hps_readdata), 64'h13);
    for (int i = 1; i <= 4; i++) begin
      chk("t3_order", 64'(bus.cmd_data[55:48]), 64'(i));
      idle(1'b1);
    end
    chk("t3_empty", 64'(bus.cmd_valid), 64'd0);
    chk("t3_sticky", 64'(bus.overflow), 64'd1);
    wr(3'd7, 8'h02, 1'b0);
    chk("t3_clr", 64'(bus.overflow), 64'd0);

    for (int t = 1; t <= 4; t++) wr(3'd6, 8'(t), 1'b0);
    wr(3'd6, 8'h09, 1'b1);
    chk("t4_ovf", 64'(bus.overflow), 64'd0);
    exp4 = '{8'h02, 8'h03, 8'h04, 8'h09};
    for (int i = 0; i < 4; i++) begin
      chk("t4_order", 64'(bus.cmd_data[55:48]), 64'(exp4[i]));
      idle(1'b1);
    end

    for (int t = 1; t <= 5; t++) wr(3'd6, 8'(t), 1'b0);
    idle(1'b1);
    wr(3'd7, 8'h03, 1'b0);
    chk("t5_valid", 64'(bus.cmd_valid), 64'd0);
    chk("t5_ovf", 64'(bus.overflow), 64'd0);
    wr(3'd6, 8'h55, 1'b0);
    chk("t5_tag", 64'(bus.cmd_data[55:48]), 64'h55);
    idle(1'b1);

    wr(3'd6, 8'ha1, 1'b0);
    wr(3'd6, 8'ha2, 1'b0);
    for (int i = 0; i < 8; i++)
      step(1'b0, 1'b1, 1'b0, 3'($urandom_range(0, 7)),
           8'($urandom), 1'b0);
    for (int i = 0; i < 6; i++) rdr(3'(i));
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk_zero("areset");
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    idle(1'b1);
    rdr(3'd0);

    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 9) < 8, $urandom_range(0, 1),
           $urandom_range(0, 9) < 3, 3'($urandom_range(0, 7)),
           8'($urandom), $urandom_range(0, 2) == 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
